// File: rtl/sm4_sbox_arbiter.sv
// Two-requester arbiter sharing one SM4 tau unit (four byte S-boxes).
// Grant is combinational; response follows two cycles later.
module sbox_replace (
    input  logic [7:0] din,
    output logic [7:0] dout
);
    localparam logic [7:0] SBOX [256] = '{
        8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7,
        8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
        8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3,
        8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
        8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a,
        8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
        8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95,
        8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
        8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba,
        8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
        8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b,
        8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
        8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2,
        8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
        8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52,
        8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
        8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5,
        8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
        8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55,
        8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
        8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60,
        8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
        8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f,
        8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
        8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f,
        8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
        8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd,
        8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
        8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e,
        8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
        8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20,
        8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
    };

    assign dout = SBOX[din];
endmodule

module sm4_sbox_arbiter #(
    parameter int FIXED_PRI = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ke_req,
    input  logic [31:0] ke_data,
    output logic        ke_gnt,
    input  logic        rf_req,
    input  logic [31:0] rf_data,
    output logic        rf_gnt,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [31:0] rsp_data,
    output logic        busy
);
    localparam logic KE_PRI = (FIXED_PRI != 0);

    // last_grant: 0 = ke, 1 = rf; reset to 1 so ke wins the first tie
    logic        last_grant_q, last_grant_d;
    logic        s1_valid_q, s1_valid_d;
    logic        s1_id_q, s1_id_d;
    logic [31:0] s1_data_q, s1_data_d;
    logic        s2_valid_q, s2_valid_d;
    logic        s2_id_q, s2_id_d;
    logic [31:0] s2_data_q, s2_data_d;
    logic [31:0] tau_out;

    for (genvar k = 0; k < 4; k++) begin : g_lane
        sbox_replace u_sbox (
            .din  (s1_data_q[8*k +: 8]),
            .dout (tau_out[8*k +: 8])
        );
    end

    always_comb begin
        ke_gnt = ke_req & (~rf_req | KE_PRI | last_grant_q);
        rf_gnt = rf_req & ~ke_gnt;
    end

    always_comb begin
        last_grant_d = last_grant_q;
        s1_valid_d   = ke_gnt | rf_gnt;
        s1_id_d      = s1_id_q;
        s1_data_d    = s1_data_q;
        s2_valid_d   = s1_valid_q;
        s2_id_d      = s2_id_q;
        s2_data_d    = s2_data_q;
        if (ke_gnt | rf_gnt) begin
            last_grant_d = rf_gnt;
            s1_id_d      = rf_gnt;
            s1_data_d    = rf_gnt ? rf_data : ke_data;
        end
        // output registers hold the last response while idle
        if (s1_valid_q) begin
            s2_id_d   = s1_id_q;
            s2_data_d = tau_out;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
            s1_valid_q   <= 1'b0;
            s1_id_q      <= 1'b0;
            s1_data_q    <= 32'h0;
            s2_valid_q   <= 1'b0;
            s2_id_q      <= 1'b0;
            s2_data_q    <= 32'h0;
        end else begin
            last_grant_q <= last_grant_d;
            s1_valid_q   <= s1_valid_d;
            s1_id_q      <= s1_id_d;
            s1_data_q    <= s1_data_d;
            s2_valid_q   <= s2_valid_d;
            s2_id_q      <= s2_id_d;
            s2_data_q    <= s2_data_d;
        end
    end

    assign rsp_valid = s2_valid_q;
    assign rsp_id    = s2_id_q;
    assign rsp_data  = s2_data_q;
    assign busy      = s1_valid_q | s2_valid_q;
endmodule

// File: doc/sm4_sbox_arbiter.md
SM4_SBOX_ARBITER -- requirements
Module: sm4_sbox_arbiter

Interface
REQ-001 Parameter FIXED_PRI, default 0: 0 selects round-robin arbitration; 1 gives the key-expansion requester fixed priority.
REQ-002 Port clk, input, 1: single clock; all flops rise-edge triggered.
REQ-003 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 Port ke_req, input, 1: key-expansion requester has a word pending.
REQ-005 Port ke_data, input, 32: key-expansion word to substitute.
REQ-006 Port ke_gnt, output, 1: key-expansion word accepted this cycle.
REQ-007 Port rf_req, input, 1: round-function requester has a word pending.
REQ-008 Port rf_data, input, 32: round-function word to substitute.
REQ-009 Port rf_gnt, output, 1: round-function word accepted this cycle.
REQ-010 Port rsp_valid, output, 1: rsp_data is valid this cycle.
REQ-011 Port rsp_id, output, 1: owner of the response; 0 = key expansion, 1 = round function.
REQ-012 Port rsp_data, output, 32: tau result, i.e. four byte S-box substitutions.
REQ-013 Port busy, output, 1: at least one pipeline stage holds a valid word.

Function
REQ-014 The block shall share one 32-bit tau unit between the two requesters; the unit is four instances of the SM4 byte S-box (sbox_replace), one per byte lane.
REQ-015 Byte mapping: rsp_data[8k+7:8k] = S(word[8k+7:8k]) for k = 0..3; no lane swap.
REQ-016 ke_gnt and rf_gnt shall be combinational from the req inputs and the arbiter state.
- At most one grant is high per cycle.
- A grant is never high without its req.
REQ-017 A single req shall be granted in the same cycle; no backpressure exists, so acceptance rate is one word per cycle.
REQ-018 Both reqs high with FIXED_PRI=1: ke always wins.
REQ-019 Both reqs high with FIXED_PRI=0: the requester not granted last wins; the last_grant flop updates only on a grant.
REQ-020 A requester shall hold req and data stable until its grant.
- A denied requester is granted in the next cycle under round-robin.
REQ-021 Pipeline stage 1 shall register the granted data, the id and valid on the edge ending the grant cycle T.
REQ-022 Stage 2 shall register the S-box output, the id and valid on the next edge.
- rsp_valid, rsp_id and rsp_data appear in cycle T+2.
- Latency is fixed at 2.
REQ-023 Responses shall return in grant order.
- No response is dropped or duplicated.
- rsp_valid is a one-cycle pulse per accepted word.
REQ-024 With no grant, stage-1 valid shall clear; with rsp_valid low, rsp_data holds its last value.
REQ-025 busy = stage-1 valid OR stage-2 valid.
REQ-026 Back-to-back grants shall produce back-to-back responses with no bubble.

Reset
REQ-027 rst_n low shall asynchronously clear:
- stage valids, so rsp_valid=0 and busy=0;
- rsp_id=0 and rsp_data=32'h0;
- last_grant=1, so ke wins the first tie.
REQ-028 Grants shall follow req combinationally during reset, but nothing shall be captured while rst_n is low.
REQ-029 Reset asserted mid-operation shall discard all in-flight words with no response; operation resumes on the first edge after rst_n rises.

Verification
REQ-030 ke_req=1, ke_data=32'h00010203 for one cycle -> ke_gnt=1 that cycle; two cycles later rsp_valid=1, rsp_id=0, rsp_data=32'hd690e9fe.
REQ-031 rf_req=1, rf_data=32'hfffefdfc -> rf_gnt=1; two cycles later rsp_valid=1, rsp_id=1, rsp_data=32'h4839cbd7.
REQ-032 FIXED_PRI=0, both reqs held high from reset for 4 cycles -> grants alternate ke, rf, ke, rf; responses follow 2 cycles later with ids 0,1,0,1 and no bubble.
REQ-033 FIXED_PRI=1, both reqs held for 3 cycles -> ke_gnt=1 and rf_gnt=0 throughout; rf is granted in the first cycle after ke_req drops.
REQ-034 Grant at cycle T, then rst_n pulsed low during cycle T+1 -> no rsp_valid at T+2, busy=0, rsp_data=32'h0; the next request after reset returns a correct result at its own grant+2.
REQ-035 Randomised reqs and data against a tau reference model -> every accepted word returns exactly once, in order, with the correct id and data; ke_gnt and rf_gnt are never high together.
